// File: rtl/ls_test_ctrl.sv
// Run sequencer for shift-register lifetime tests: syncs to the returned pattern,
// then counts per-channel Q/DATA mismatches over a programmed window.
module ls_test_ctrl #(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned WIN_W   = 16,
    parameter int unsigned SYNC_TO = 1023,
    localparam int unsigned NCH    = 2 ** SEL_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIN_W-1:0] WINDOW,
    input  logic [NCH-1:0]   CH_EN,
    input  logic [NCH-1:0]   Q,
    input  logic             DATA,
    output logic             GEN_EN,
    output logic             BUSY,
    output logic             DONE,
    output logic             TIMEOUT,
    output logic             ERR_ANY,
    input  logic [SEL_W-1:0] RD_SEL,
    output logic [CNT_W-1:0] RD_CNT
);

    localparam int unsigned TO_W = $clog2(SYNC_TO + 1);

    typedef enum logic [1:0] {StIdle, StArm, StRun, StFin} state_e;

    state_e           state_q, state_d;
    logic [NCH-1:0]   q_s1_q, qs_q, qs_dly_q;
    logic             d_s1_q, dd_q;
    logic [WIN_W-1:0] win_lat_q, win_lat_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [NCH-1:0]   en_lat_q, en_lat_d;
    logic [NCH-1:0]   seen_q, seen_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic             err_any_q, err_any_d;

    logic [NCH-1:0]   seen_now;
    logic             synced;

    // Q is asynchronous; DATA takes the same two-flop delay so both line up at compare
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_s1_q   <= '0;
            qs_q     <= '0;
            qs_dly_q <= '0;
            d_s1_q   <= 1'b0;
            dd_q     <= 1'b0;
        end else begin
            q_s1_q   <= Q;
            qs_q     <= q_s1_q;
            qs_dly_q <= qs_q;
            d_s1_q   <= DATA;
            dd_q     <= d_s1_q;
        end
    end

    // Including this cycle's edges lets sync win over a coincident timeout
    assign seen_now = seen_q | (qs_q & ~qs_dly_q);
    assign synced   = &(seen_now | ~en_lat_q);

    always_comb begin
        state_d   = state_q;
        win_lat_d = win_lat_q;
        win_cnt_d = win_cnt_q;
        en_lat_d  = en_lat_q;
        seen_d    = seen_q;
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    win_lat_d = (WINDOW == '0) ? WIN_W'(1) : WINDOW;
                    en_lat_d  = CH_EN;
                    seen_d    = '0;
                    to_cnt_d  = '0;
                    timeout_d = 1'b0;
                    for (int i = 0; i < int'(NCH); i++) begin
                        cnt_d[i] = '0;
                    end
                    state_d = StArm;
                end
            end
            StArm: begin
                seen_d = seen_now;
                if (synced) begin
                    win_cnt_d = win_lat_q;
                    state_d   = StRun;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_q == TO_W'(SYNC_TO - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = StFin;
                    end
                end
            end
            StRun: begin
                for (int i = 0; i < int'(NCH); i++) begin
                    if (en_lat_q[i] && (qs_q[i] ^ dd_q) && (cnt_q[i] != '1)) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                win_cnt_d = win_cnt_q - WIN_W'(1);
                if (win_cnt_q == WIN_W'(1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        err_any_d = 1'b0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (cnt_q[i] != '0) begin
                err_any_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            win_lat_q <= '0;
            win_cnt_q <= '0;
            en_lat_q  <= '0;
            seen_q    <= '0;
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
            err_any_q <= 1'b0;
            for (int i = 0; i < int'(NCH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            win_lat_q <= win_lat_d;
            win_cnt_q <= win_cnt_d;
            en_lat_q  <= en_lat_d;
            seen_q    <= seen_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
            err_any_q <= err_any_d;
            cnt_q     <= cnt_d;
        end
    end

    assign GEN_EN  = (state_q == StArm) || (state_q == StRun);
    assign BUSY    = (state_q != StIdle);
    assign DONE    = (state_q == StFin);
    assign TIMEOUT = timeout_q;
    assign ERR_ANY = err_any_q;
    assign RD_CNT  = cnt_q[RD_SEL];

endmodule

// File: tb/tb_ls_test_ctrl.sv
// Bench for ls_test_ctrl: directed and random runs against a sample-history model,
// driving a default instance and a 4-bit-counter instance from the same stimulus.
module tb_ls_test_ctrl;

    localparam int SYNC_TO = 1023;

    logic        CLK, RST, START, DATA;
    logic [15:0] WINDOW;
    logic [3:0]  CH_EN, Q;
    logic [1:0]  RD_SEL;
    logic        gen_en, busy, done, timeout, err_any;
    logic        gen_en_s, busy_s, done_s, timeout_s, err_any_s;
    logic [11:0] rd_cnt;
    logic [3:0]  rd_cnt_s;

    ls_test_ctrl dut (
        .CLK(CLK), .RST(RST), .START(START), .WINDOW(WINDOW), .CH_EN(CH_EN), .Q(Q),
        .DATA(DATA), .GEN_EN(gen_en), .BUSY(busy), .DONE(done), .TIMEOUT(timeout),
        .ERR_ANY(err_any), .RD_SEL(RD_SEL), .RD_CNT(rd_cnt)
    );

    ls_test_ctrl #(.CNT_W(4)) dut_s (
        .CLK(CLK), .RST(RST), .START(START), .WINDOW(WINDOW), .CH_EN(CH_EN), .Q(Q),
        .DATA(DATA), .GEN_EN(gen_en_s), .BUSY(busy_s), .DONE(done_s), .TIMEOUT(timeout_s),
        .ERR_ANY(err_any_s), .RD_SEL(RD_SEL), .RD_CNT(rd_cnt_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [3:0] hq[$];
    logic       hd[$];
    int         ch_mode[4];
    int         done_cnt, done_cnt_s, done_edge, done_edge_s;
    int         exp_k, exp_dedge;
    logic       exp_to;
    int         exp_cnt[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Mode per channel: 0 loopback, 1 inverted, 2 stuck low, 3 independent random
    task automatic drive();
        DATA = 1'($urandom);
        for (int i = 0; i < 4; i++) begin
            case (ch_mode[i])
                0:       Q[i] = DATA;
                1:       Q[i] = ~DATA;
                2:       Q[i] = 1'b0;
                default: Q[i] = 1'($urandom);
            endcase
        end
    endtask

    task automatic step();
        @(posedge CLK);
        hq.push_back(Q);
        hd.push_back(DATA);
        #2;
        if (done === 1'b1) begin
            done_cnt++;
            done_edge = hq.size() - 1;
        end
        if (done_s === 1'b1) begin
            done_cnt_s++;
            done_edge_s = hq.size() - 1;
        end
    endtask

    // Edge index e samples hq[e]; the DUT compares samples two edges old.
    // ARM cycle k looks for a 0->1 between samples t0+k-3 and t0+k-2;
    // RUN cycle m compares sample t0+k+m-2 of Q against DATA.
    task automatic predict(input int t0, input int w, input logic [3:0] en, input int last_edge);
        logic [3:0] seen;
        int weff;
        seen  = 4'h0;
        weff  = (w == 0) ? 1 : w;
        exp_k = 0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        for (int k = 1; k <= SYNC_TO; k++) begin
            if (t0 + k - 2 >= hq.size()) break;
            seen |= hq[t0+k-2] & ~hq[t0+k-3];
            if ((seen | ~en) == 4'hf) begin
                exp_k = k;
                break;
            end
        end
        exp_to = (exp_k == 0);
        if (exp_to) begin
            exp_dedge = t0 + SYNC_TO;
        end else begin
            exp_dedge = t0 + exp_k + weff;
            for (int m = 1; m <= weff && t0 + exp_k + m <= last_edge; m++) begin
                for (int i = 0; i < 4; i++) begin
                    if (en[i] && (hq[t0+exp_k+m-2][i] != hd[t0+exp_k+m-2])) exp_cnt[i]++;
                end
            end
        end
    endtask

    task automatic check_counts(input string tag);
        int any;
        any = 0;
        for (int i = 0; i < 4; i++) begin
            RD_SEL = 2'(i);
            #1;
            chk($sformatf("%s cnt%0d", tag, i), 32'(rd_cnt),
                (exp_cnt[i] > 4095) ? 4095 : exp_cnt[i]);
            chk($sformatf("%s sat cnt%0d", tag, i), 32'(rd_cnt_s),
                (exp_cnt[i] > 15) ? 15 : exp_cnt[i]);
            if (exp_cnt[i] != 0) any = 1;
        end
        chk({tag, " err_any"}, 32'(err_any), any);
        chk({tag, " sat err_any"}, 32'(err_any_s), any);
    endtask

    task automatic do_run(input string tag, input logic [15:0] win, input logic [3:0] en,
                          input bit hold);
        int t0, n;
        START  = 1'b1;
        WINDOW = win;
        CH_EN  = en;
        drive();
        step();
        t0 = hq.size() - 1;
        chk({tag, " busy after start"}, 32'(busy), 1);
        chk({tag, " gen_en after start"}, 32'(gen_en), 1);
        chk({tag, " timeout cleared"}, 32'(timeout), 0);
        if (!hold) START = 1'b0;
        // Both are latched at START, so later changes must have no effect
        WINDOW = 16'($urandom);
        CH_EN  = 4'($urandom);
        done_cnt = 0; done_cnt_s = 0; done_edge = -1; done_edge_s = -1;
        n = 0;
        while (busy === 1'b1 && n < SYNC_TO + 300) begin
            drive();
            step();
            n++;
            if (done === 1'b1) chk({tag, " gen_en in fin"}, 32'(gen_en), 0);
        end
        predict(t0, int'(win), en, hq.size() - 1);
        chk({tag, " busy fell"}, 32'(busy), 0);
        chk({tag, " busy fall edge"}, hq.size() - 1, exp_dedge + 1);
        chk({tag, " done pulses"}, done_cnt, 1);
        chk({tag, " sat done pulses"}, done_cnt_s, 1);
        chk({tag, " done edge"}, done_edge, exp_dedge);
        chk({tag, " sat done edge"}, done_edge_s, exp_dedge);
        chk({tag, " timeout"}, 32'(timeout), 32'(exp_to));
        chk({tag, " sat timeout"}, 32'(timeout_s), 32'(exp_to));
        check_counts(tag);
    endtask

    initial begin
        int t0;
        RST = 1'b1; START = 1'b0; WINDOW = '0; CH_EN = '0; Q = '0; DATA = 1'b0; RD_SEL = '0;
        for (int i = 0; i < 4; i++) ch_mode[i] = 2;
        done_cnt = 0; done_cnt_s = 0;
        repeat (3) begin drive(); step(); end
        chk("reset busy", 32'(busy), 0);
        chk("reset gen_en", 32'(gen_en), 0);
        chk("reset done", 32'(done), 0);
        chk("reset timeout", 32'(timeout), 0);
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        check_counts("reset");
        RST = 1'b0;
        repeat (4) begin drive(); step(); end

        ch_mode = '{0, 0, 0, 0};
        do_run("loopback", 16'd100, 4'hf, 1'b0);

        ch_mode = '{0, 0, 1, 0};
        do_run("inv2", 16'd100, 4'hf, 1'b0);
        RD_SEL = 2'd2; #1;
        chk("inv2 rd_cnt literal", 32'(rd_cnt), 100);

        ch_mode = '{2, 0, 0, 0};
        do_run("timeout", 16'd10, 4'b0011, 1'b0);
        chk("timeout literal", 32'(timeout), 1);
        chk("timeout gen_en", 32'(gen_en), 0);

        ch_mode = '{0, 1, 0, 0};
        do_run("sat", 16'd40, 4'hf, 1'b0);
        RD_SEL = 2'd1; #1;
        chk("sat literal", 32'(rd_cnt_s), 15);
        chk("nosat literal", 32'(rd_cnt), 40);

        // Reset partway through a run with mismatches accumulated
        ch_mode = '{0, 1, 0, 0};
        START = 1'b1; WINDOW = 16'd100; CH_EN = 4'hf;
        drive(); step();
        t0 = hq.size() - 1;
        START = 1'b0;
        repeat (40) begin drive(); step(); end
        predict(t0, 100, 4'hf, hq.size() - 1);
        check_counts("mid-run");
        chk("mid-run still busy", 32'(busy), 1);
        done_cnt = 0; done_cnt_s = 0;
        #1 RST = 1'b1;
        #1;
        chk("rst busy", 32'(busy), 0);
        chk("rst gen_en", 32'(gen_en), 0);
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        check_counts("rst");
        ch_mode = '{2, 2, 2, 2};
        repeat (3) begin drive(); step(); end
        RST = 1'b0;
        repeat (4) begin drive(); step(); end
        chk("rst no done", done_cnt + done_cnt_s, 0);
        chk("rst idle", 32'(busy), 0);
        ch_mode = '{0, 1, 0, 0};
        do_run("post-rst", 16'd50, 4'hf, 1'b0);

        // START held through two back-to-back runs with WINDOW = 0
        ch_mode = '{0, 0, 0, 1};
        do_run("hold1", 16'd0, 4'hf, 1'b1);
        RD_SEL = 2'd3; #1;
        chk("hold1 one compare", 32'(rd_cnt), 1);
        do_run("hold2", 16'd0, 4'hf, 1'b1);
        START = 1'b0;

        ch_mode = '{1, 1, 1, 1};
        do_run("en0", 16'd5, 4'h0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) ch_mode[i] = int'($urandom_range(3, 0));
            do_run($sformatf("rand%0d", r), 16'($urandom_range(60, 0)), 4'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
